// File: rtl/combat_arbiter_pkg.sv
// Shared encodings, frame lengths and round limits for the combat arbiter.
package combat_arbiter_pkg;

  localparam logic [1:0] PH_IDLE     = 2'd0;
  localparam logic [1:0] PH_STARTUP  = 2'd1;
  localparam logic [1:0] PH_ACTIVE   = 2'd2;
  localparam logic [1:0] PH_RECOVERY = 2'd3;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_P1   = 2'b01;
  localparam logic [1:0] GNT_P2   = 2'b10;

  localparam int STARTUP_FRAMES  = 5;
  localparam int ACTIVE_FRAMES   = 2;
  localparam int RECOVERY_FRAMES = 8;
  localparam int TICKS_PER_SEC   = 60;
  localparam int TIME_MAX        = 99;

  localparam logic [1:0] HEALTH_MAX   = 2'd3;
  localparam logic [7:0] TIME_MAX_BCD = {4'(TIME_MAX / 10), 4'(TIME_MAX % 10)};

  // Index of the last frame of a phase; the phase ends on the tick that sees it.
  function automatic logic [2:0] last_frame(input logic [1:0] ph);
    case (ph)
      PH_STARTUP:  return 3'(STARTUP_FRAMES - 1);
      PH_ACTIVE:   return 3'(ACTIVE_FRAMES - 1);
      PH_RECOVERY: return 3'(RECOVERY_FRAMES - 1);
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [1:0] health_dec(input logic [1:0] h);
    return (h == 2'd0) ? 2'd0 : h - 2'd1;
  endfunction

endpackage

// File: rtl/combat_arbiter_timer.sv
// Round timer: counts frame ticks into BCD seconds, saturating at TIME_MAX.
module round_timer
  import combat_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clear,
  input  logic       freeze,
  output logic [7:0] time_bcd
);

  logic [5:0] sub_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt  <= '0;
      time_bcd <= '0;
    end else if (clear) begin
      sub_cnt  <= '0;
      time_bcd <= '0;
    end else if (tick && !freeze) begin
      if (sub_cnt == 6'(TICKS_PER_SEC - 1)) begin
        sub_cnt <= '0;
        if (time_bcd != TIME_MAX_BCD) time_bcd <= bcd_inc(time_bcd);
      end else begin
        sub_cnt <= sub_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/combat_arbiter.sv
// Single shared hit resource: round-robin grant, startup/active/recovery
// frame sequencing, damage and round timer.
module combat_arbiter
  import combat_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       p1_atk_req,
  input  logic       p2_atk_req,
  input  logic       p1_block,
  input  logic       p2_block,
  input  logic       in_range,
  output logic [1:0] health1,
  output logic [1:0] health2,
  output logic [7:0] time_counter,
  output logic [1:0] grant,
  output logic [1:0] atk_phase,
  output logic       hit_p1,
  output logic       hit_p2
);

  logic       running;
  logic       pend1;
  logic       pend2;
  logic       prio_p2;
  logic       hit_done;
  logic [2:0] frame_cnt;
  logic       frozen;
  logic       owner_p1;
  logic       owner_p2;
  logic       cand1;
  logic       cand2;
  logic       p1_wins;
  logic       def_block;

  assign frozen    = !running || game_over || (health1 == 2'd0) || (health2 == 2'd0);
  assign owner_p1  = (grant == GNT_P1);
  assign owner_p2  = (grant == GNT_P2);
  assign def_block = owner_p1 ? p2_block : p1_block;

  // The owner never contends, so outside IDLE only the other player can be a candidate.
  always_comb begin
    cand1   = pend1 || (p1_atk_req && !owner_p1);
    cand2   = pend2 || (p2_atk_req && !owner_p2);
    p1_wins = cand1 && (!cand2 || !prio_p2);
  end

  round_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (frame_tick),
    .clear    (game_start),
    .freeze   (frozen),
    .time_bcd (time_counter)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health1   <= HEALTH_MAX;
      health2   <= HEALTH_MAX;
      grant     <= GNT_NONE;
      atk_phase <= PH_IDLE;
      hit_p1    <= 1'b0;
      hit_p2    <= 1'b0;
      pend1     <= 1'b0;
      pend2     <= 1'b0;
      prio_p2   <= 1'b0;
      hit_done  <= 1'b0;
      frame_cnt <= '0;
      running   <= 1'b0;
    end else begin
      hit_p1 <= 1'b0;
      hit_p2 <= 1'b0;
      if (game_start) begin
        health1   <= HEALTH_MAX;
        health2   <= HEALTH_MAX;
        grant     <= GNT_NONE;
        atk_phase <= PH_IDLE;
        pend1     <= 1'b0;
        pend2     <= 1'b0;
        hit_done  <= 1'b0;
        frame_cnt <= '0;
        running   <= 1'b1;
      end else if (!frozen) begin
        if (atk_phase == PH_IDLE) begin
          if (cand1 || cand2) begin
            atk_phase <= PH_STARTUP;
            frame_cnt <= '0;
            hit_done  <= 1'b0;
            if (p1_wins) begin
              grant   <= GNT_P1;
              pend1   <= 1'b0;
              pend2   <= cand2;
              prio_p2 <= 1'b1;
            end else begin
              grant   <= GNT_P2;
              pend2   <= 1'b0;
              pend1   <= cand1;
              prio_p2 <= 1'b0;
            end
          end
        end else begin
          if (p1_atk_req && !owner_p1) pend1 <= 1'b1;
          if (p2_atk_req && !owner_p2) pend2 <= 1'b1;
          if (frame_tick) begin
            if (atk_phase == PH_ACTIVE && !hit_done && in_range && !def_block) begin
              hit_done <= 1'b1;
              if (owner_p1) begin
                health2 <= health_dec(health2);
                hit_p2  <= 1'b1;
              end else begin
                health1 <= health_dec(health1);
                hit_p1  <= 1'b1;
              end
            end
            if (frame_cnt == last_frame(atk_phase)) begin
              frame_cnt <= '0;
              if (atk_phase == PH_RECOVERY) begin
                // A waiting challenger takes the resource without passing through IDLE.
                if (cand1) begin
                  grant     <= GNT_P1;
                  pend1     <= 1'b0;
                  prio_p2   <= 1'b1;
                  hit_done  <= 1'b0;
                  atk_phase <= PH_STARTUP;
                end else if (cand2) begin
                  grant     <= GNT_P2;
                  pend2     <= 1'b0;
                  prio_p2   <= 1'b0;
                  hit_done  <= 1'b0;
                  atk_phase <= PH_STARTUP;
                end else begin
                  grant     <= GNT_NONE;
                  atk_phase <= PH_IDLE;
                end
              end else begin
                atk_phase <= atk_phase + 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 3'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_combat_arbiter.sv
// Scoreboard bench for combat_arbiter: directed stimulus queues expected grant/hit
// events and state snapshots; a negedge monitor pops and compares them.
module tb_combat_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_tick = 1'b0;
  logic game_start = 1'b0;
  logic game_over = 1'b0;
  logic p1_atk_req = 1'b0;
  logic p2_atk_req = 1'b0;
  logic p1_block = 1'b0;
  logic p2_block = 1'b0;
  logic in_range = 1'b0;
  logic [1:0] health1;
  logic [1:0] health2;
  logic [7:0] time_counter;
  logic [1:0] grant;
  logic [1:0] atk_phase;
  logic hit_p1;
  logic hit_p2;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_HIT1  = 2'd1;
  localparam logic [1:0] EV_HIT2  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] val;
  } ev_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [1:0] h2;
    logic [7:0] t;
    logic [1:0] g;
    logic [1:0] ph;
  } snap_t;

  ev_t   evq[$];
  snap_t snapq[$];
  string snapname[$];
  logic [1:0] prev_grant = 2'b00;

  combat_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .game_start   (game_start),
    .game_over    (game_over),
    .p1_atk_req   (p1_atk_req),
    .p2_atk_req   (p2_atk_req),
    .p1_block     (p1_block),
    .p2_block     (p2_block),
    .in_range     (in_range),
    .health1      (health1),
    .health2      (health2),
    .time_counter (time_counter),
    .grant        (grant),
    .atk_phase    (atk_phase),
    .hit_p1       (hit_p1),
    .hit_p2       (hit_p2)
  );

  always #5 clk = ~clk;

  // Monitor: every grant change or hit pulse is a DUT event matched against evq.
  task automatic check_event(input ev_t got);
    ev_t exp;
    vectors++;
    if (evq.size() == 0) begin
      miscompares++;
      $display("FAIL event: got kind=%0d val=%0d, required no event (t=%0t)", got.kind, got.val, $time);
    end else begin
      exp = evq.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%0d, required kind=%0d val=%0d (t=%0t)",
                 got.kind, got.val, exp.kind, exp.val, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    snap_t got;
    snap_t exp;
    string nm;
    if (grant !== prev_grant) check_event(ev_t'{EV_GRANT, grant});
    prev_grant = grant;
    if (hit_p1) check_event(ev_t'{EV_HIT1, 2'd1});
    if (hit_p2) check_event(ev_t'{EV_HIT2, 2'd1});
    if (snapq.size() > 0) begin
      exp = snapq.pop_front();
      nm  = snapname.pop_front();
      got = '{health1, health2, time_counter, grant, atk_phase};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s: got h1=%0d h2=%0d time=%h grant=%b phase=%0d, required h1=%0d h2=%0d time=%h grant=%b phase=%0d",
                 nm, got.h1, got.h2, got.t, got.g, got.ph, exp.h1, exp.h2, exp.t, exp.g, exp.ph);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic req(input logic a, input logic b);
    p1_atk_req = a;
    p2_atk_req = b;
    step();
    p1_atk_req = 1'b0;
    p2_atk_req = 1'b0;
  endtask

  task automatic start_round();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [1:0] v);
    evq.push_back(ev_t'{k, v});
  endtask

  task automatic snap(input string nm, input logic [1:0] h1, input logic [1:0] h2,
                      input logic [7:0] t, input logic [1:0] g, input logic [1:0] ph);
    snapq.push_back(snap_t'{h1, h2, t, g, ph});
    snapname.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    snap("reset_state", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);

    // Before any game_start: requests ignored, timer idle
    req(1'b1, 1'b0);
    ticks(3);
    snap("pre_start", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);

    start_round();
    snap("after_start", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);

    // P1 attack lands on P2
    in_range = 1'b1;
    expect_ev(EV_GRANT, 2'b01);
    req(1'b1, 1'b0);
    snap("grant_next_cycle", 2'd3, 2'd3, 8'h00, 2'b01, 2'd1);
    req(1'b1, 1'b0);
    ticks(5);
    snap("active_after_5", 2'd3, 2'd3, 8'h00, 2'b01, 2'd2);
    expect_ev(EV_HIT2, 2'd1);
    ticks(1);
    snap("hit_tick6", 2'd3, 2'd2, 8'h00, 2'b01, 2'd2);
    ticks(1);
    snap("recovery_tick7", 2'd3, 2'd2, 8'h00, 2'b01, 2'd3);
    ticks(7);
    snap("recovery_tick14", 2'd3, 2'd2, 8'h00, 2'b01, 2'd3);
    expect_ev(EV_GRANT, 2'b00);
    ticks(1);
    snap("idle_tick15", 2'd3, 2'd2, 8'h00, 2'b00, 2'd0);

    // Round-robin tie after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start_round();
    in_range = 1'b0;
    expect_ev(EV_GRANT, 2'b01);
    req(1'b1, 1'b1);
    snap("tie_p1_first", 2'd3, 2'd3, 8'h00, 2'b01, 2'd1);
    ticks(14);
    expect_ev(EV_GRANT, 2'b10);
    ticks(1);
    snap("pending_p2_handoff", 2'd3, 2'd3, 8'h00, 2'b10, 2'd1);
    expect_ev(EV_GRANT, 2'b00);
    ticks(15);
    snap("p2_done_idle", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);
    expect_ev(EV_GRANT, 2'b01);
    req(1'b1, 1'b1);
    snap("second_tie_p1", 2'd3, 2'd3, 8'h00, 2'b01, 2'd1);
    expect_ev(EV_GRANT, 2'b00);
    start_round();
    snap("start_clears", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);

    // P2 blocks through P1's ACTIVE phase
    in_range = 1'b1;
    p2_block = 1'b1;
    expect_ev(EV_GRANT, 2'b01);
    expect_ev(EV_GRANT, 2'b00);
    req(1'b1, 1'b0);
    ticks(15);
    snap("blocked_no_hit", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);
    p2_block = 1'b0;

    // game_over freezes requests and timer
    start_round();
    game_over = 1'b1;
    req(1'b1, 1'b0);
    ticks(61);
    snap("game_over_freeze", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);
    game_over = 1'b0;

    // Three hits kill P2; everything freezes until game_start
    start_round();
    for (int k = 0; k < 2; k++) begin
      expect_ev(EV_GRANT, 2'b01);
      expect_ev(EV_HIT2, 2'd1);
      expect_ev(EV_GRANT, 2'b00);
      req(1'b1, 1'b0);
      ticks(15);
    end
    snap("two_hits", 2'd3, 2'd1, 8'h00, 2'b00, 2'd0);
    expect_ev(EV_GRANT, 2'b01);
    expect_ev(EV_HIT2, 2'd1);
    req(1'b1, 1'b0);
    ticks(6);
    snap("dead_p2", 2'd3, 2'd0, 8'h00, 2'b01, 2'd2);
    ticks(9);
    req(1'b0, 1'b1);
    ticks(30);
    snap("dead_frozen", 2'd3, 2'd0, 8'h00, 2'b01, 2'd2);
    expect_ev(EV_GRANT, 2'b00);
    start_round();
    snap("restart_after_ko", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);

    // BCD timer carry and saturation
    in_range = 1'b0;
    ticks(599);
    snap("time_599", 2'd3, 2'd3, 8'h09, 2'b00, 2'd0);
    ticks(1);
    snap("time_600_carry", 2'd3, 2'd3, 8'h10, 2'b00, 2'd0);
    ticks(5399);
    snap("time_5999", 2'd3, 2'd3, 8'h99, 2'b00, 2'd0);
    ticks(100);
    snap("time_saturated", 2'd3, 2'd3, 8'h99, 2'b00, 2'd0);

    // Reset during ACTIVE aborts without a hit
    start_round();
    in_range = 1'b1;
    expect_ev(EV_GRANT, 2'b01);
    req(1'b1, 1'b0);
    ticks(5);
    snap("active_before_rst", 2'd3, 2'd3, 8'h00, 2'b01, 2'd2);
    expect_ev(EV_GRANT, 2'b00);
    frame_tick = 1'b1;
    rst_n = 1'b0;
    snap("rst_mid_active", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);
    frame_tick = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    snap("after_rst_release", 2'd3, 2'd3, 8'h00, 2'b00, 2'd0);

    repeat (3) step();
    while (evq.size() > 0) begin
      ev_t lost;
      lost = evq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got nothing, required kind=%0d val=%0d", lost.kind, lost.val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/combat_arbiter.md
COMBAT_ARBITER -- requirements
Module: combat_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, system clock; the single clock for all logic.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port frame_tick, input, 1, one-cycle pulse at 60 Hz; all frame counts below advance only on it.
REQ-004 SHALL have port game_start, input, 1, one-cycle pulse that begins a round.
REQ-005 SHALL have port game_over, input, 1, level; freezes the arbiter while high.
REQ-006 SHALL have ports p1_atk_req / p2_atk_req, input, 1 each, attack request pulses.
REQ-007 SHALL have ports p1_block / p2_block, input, 1 each, defender blocking level.
REQ-008 SHALL have port in_range, input, 1, level; players are within hit distance.
REQ-009 SHALL have ports health1 / health2, output, 2 each, player health, 3 = full, 0 = dead.
REQ-010 SHALL have port time_counter, output, 8, elapsed round seconds, BCD: [7:4] tens, [3:0] ones.
REQ-011 SHALL have port grant, output, 2, attack owner: 00 none, 01 P1, 10 P2; never 11.
REQ-012 SHALL have port atk_phase, output, 2, 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY.
REQ-013 SHALL have ports hit_p1 / hit_p2, output, 1 each, one-cycle pulse when that player takes damage.

Function
REQ-014 The single shared hit resource SHALL carry at most one attack in flight; FSM IDLE->STARTUP->ACTIVE->RECOVERY->IDLE.
REQ-015 STARTUP SHALL last 5 frame_ticks, ACTIVE 2, RECOVERY 8; the transition takes effect in the cycle after the counting tick.
REQ-016 In IDLE, a request or pending flag SHALL be granted in the next cycle: grant set, phase = STARTUP.
REQ-017 Simultaneous contenders in IDLE SHALL be resolved round-robin; the player not granted last wins; after reset P1 has priority.
REQ-018 A request from the non-owner while not IDLE SHALL set a 1-deep pending flag; repeats do not stack; the owner's own requests SHALL be ignored.
REQ-019 A pending flag SHALL be cleared when its player is granted.
REQ-020 In ACTIVE, on the first frame_tick with in_range=1 and the defender not blocking, defender health SHALL decrement by 1 and its hit pulse SHALL fire; max one hit per attack; health saturates at 0.
REQ-021 grant SHALL return to 00 in the cycle phase returns to IDLE, unless a pending grant is issued that same transition.
REQ-022 After game_start, time_counter SHALL increment every 60 frame_ticks in BCD (09->10); it saturates at 99.
REQ-023 While game_over=1 or either health=0, the timer, FSM, health and requests SHALL all freeze (outputs hold).
REQ-024 game_start SHALL set health to 3/3, time to 00, phase IDLE, grant 00, clear pending and the sub-second count; it overrides simultaneous requests.
REQ-025 Before the first game_start after reset, all requests SHALL be ignored and the timer SHALL not run.

Reset
REQ-026 On rst_n low: health1=health2=3, time_counter=00, grant=00, atk_phase=IDLE, hit pulses 0, pending cleared, round-robin favours P1, round not running.
REQ-027 Reset asserted mid-attack SHALL abort the attack immediately with no hit issued.

Structure
REQ-028 A shared package SHALL hold the phase encodings, the frame lengths (5/2/8), TICKS_PER_SEC=60, HEALTH_MAX=3 and TIME_MAX=99.
REQ-029 The BCD seconds timer SHALL be one sub-module, round_timer (tick in, clear, freeze, 8-bit BCD out).

Verification
REQ-030 Bench SHALL cover: P1 req, in_range=1, no block -> grant=01 next cycle; hit_p2 after tick 6; health2 3->2; IDLE after tick 15.
REQ-031 Bench SHALL cover: P1 and P2 req in the same cycle after reset -> P1 granted; P2 pending; P2 granted on P1 returning to IDLE; the next tie goes to P1.
REQ-032 Bench SHALL cover: p2_block=1 throughout P1's ACTIVE phase -> no hit_p2; health2 unchanged.
REQ-033 Bench SHALL cover: 5999 ticks -> time=99; further ticks -> stays 99; the 600th tick shows the 09->10 carry.
REQ-034 Bench SHALL cover: health2 driven to 0 by three hits -> all outputs freeze; game_start -> 3/3, 00, IDLE.
REQ-035 Bench SHALL cover: rst_n low during ACTIVE -> immediate IDLE, grant=00, no hit pulse, health 3/3.
